// File: rtl/zarv_top.sv
// zarv: minimal single-cycle RV32I core with on-chip ROM, RAM and regfile.
// Fetch, decode, execute and writeback are combinational; state commits on clk.
module zarv_rom #(
  parameter int DEPTH = 1024
) (
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic [31:0]              data
);
  reg [31:0] _rom [0:DEPTH-1];

  assign data = _rom[addr];
endmodule

module zarv_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic [31:0] qa,
  output logic [31:0] qb,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  reg [31:0] regs [0:31];

  assign qa = (ra == 5'd0) ? 32'd0 : regs[ra];
  assign qb = (rb == 5'd0) ? 32'd0 : regs[rb];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end
endmodule

module zarv_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  reg [31:0] mem [0:DEPTH-1];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

module zarv_top #(
  parameter int ROM_DEPTH = 1024,
  parameter int RAM_DEPTH = 1024
) (
  input logic clk,
  input logic rst_n
);
  localparam int RA = $clog2(ROM_DEPTH);
  localparam int DA = $clog2(RAM_DEPTH);

  logic [31:0] pc, pc_next, instr;
  logic [31:0] rs1_v, rs2_v, ram_q;
  logic [31:0] wb, addr, op_b, alu_y;
  logic        wb_en, taken, alu_alt, unused_bits;

  zarv_rom #(.DEPTH(ROM_DEPTH)) u_rom (
    .addr (pc[RA+1:2]),
    .data (instr)
  );

  logic [6:0] opc, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;

  assign opc = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign f7  = instr[31:25];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{21{instr[31]}}, instr[30:20]};
  assign imm_s = {{21{instr[31]}}, instr[30:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25],
                  instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20],
                  instr[30:21], 1'b0};

  logic op_ok, opi_ok;
  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_lw, is_sw, is_opi, is_op;

  // Only SUB/SRA(I) may set funct7[5]; any other funct7 is an illegal NOP.
  assign op_ok  = (f7 == 7'h00) ||
                  (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
  assign opi_ok = (f3 == 3'b001) ? (f7 == 7'h00) :
                  (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) :
                  1'b1;

  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111 && f3 == 3'b000;
  assign is_br    = opc == 7'b1100011 && f3[2:1] != 2'b01;
  assign is_lw    = opc == 7'b0000011 && f3 == 3'b010;
  assign is_sw    = opc == 7'b0100011 && f3 == 3'b010;
  assign is_opi   = opc == 7'b0010011 && opi_ok;
  assign is_op    = opc == 7'b0110011 && op_ok;

  zarv_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra    (rs1),
    .rb    (rs2),
    .qa    (rs1_v),
    .qb    (rs2_v),
    .we    (wb_en),
    .wa    (rd),
    .wd    (wb)
  );

  assign addr = rs1_v + (is_sw ? imm_s : imm_i);
  assign unused_bits = ^{addr[31:DA+2], addr[1:0]};

  zarv_ram #(.DEPTH(RAM_DEPTH)) u_ram (
    .clk   (clk),
    .we    (is_sw && rst_n),
    .addr  (addr[DA+1:2]),
    .wdata (rs2_v),
    .rdata (ram_q)
  );

  assign op_b    = is_op ? rs2_v : imm_i;
  assign alu_alt = is_op ? f7[5] : (f3 == 3'b101 && f7[5]);

  always_comb begin
    alu_y = '0;
    case (f3)
      3'b000: alu_y = alu_alt ? rs1_v - op_b : rs1_v + op_b;
      3'b001: alu_y = rs1_v << op_b[4:0];
      3'b010: alu_y = {31'd0, $signed(rs1_v) < $signed(op_b)};
      3'b011: alu_y = {31'd0, rs1_v < op_b};
      3'b100: alu_y = rs1_v ^ op_b;
      3'b101: alu_y = alu_alt ? 32'($signed(rs1_v) >>> op_b[4:0])
                              : rs1_v >> op_b[4:0];
      3'b110: alu_y = rs1_v | op_b;
      3'b111: alu_y = rs1_v & op_b;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000: taken = rs1_v == rs2_v;
      3'b001: taken = rs1_v != rs2_v;
      3'b100: taken = $signed(rs1_v) < $signed(rs2_v);
      3'b101: taken = $signed(rs1_v) >= $signed(rs2_v);
      3'b110: taken = rs1_v < rs2_v;
      3'b111: taken = rs1_v >= rs2_v;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_next = pc + 32'd4;
    wb_en   = 1'b0;
    wb      = '0;
    unique case (1'b1)
      is_lui: begin
        wb_en = 1'b1;
        wb    = imm_u;
      end
      is_auipc: begin
        wb_en = 1'b1;
        wb    = pc + imm_u;
      end
      is_jal: begin
        wb_en   = 1'b1;
        wb      = pc + 32'd4;
        pc_next = pc + imm_j;
      end
      is_jalr: begin
        wb_en   = 1'b1;
        wb      = pc + 32'd4;
        pc_next = (rs1_v + imm_i) & ~32'd1;
      end
      is_br: begin
        if (taken) pc_next = pc + imm_b;
      end
      is_lw: begin
        wb_en = 1'b1;
        wb    = ram_q;
      end
      is_opi, is_op: begin
        wb_en = 1'b1;
        wb    = alu_y;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else        pc <= pc_next;
  end
endmodule

// File: tb/tb_zarv_top.sv
// Bench for zarv_top: directed program plus random programs, checked per
// cycle by a scoreboard against an instruction-level reference model.
module tb_zarv_top;
  localparam int RD = 1024;
  localparam int MD = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  zarv_top #(.ROM_DEPTH(RD), .RAM_DEPTH(MD)) dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0][31:0] regs;
    logic              mchk;
    logic [9:0]        midx;
    logic [31:0]       mval;
  } exp_t;

  exp_t q[$];

  logic [31:0] m_rom [RD];
  logic [31:0] m_regs [32];
  logic [31:0] m_mem [MD];
  logic [31:0] m_pc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] r_t(input int f7, f3, rd, rs1, rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] i_t(input int op, f3, rd, rs1, imm);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction

  function automatic logic [31:0] s_t(input int rs1, rs2, imm);
    logic [11:0] v;
    v = 12'(imm);
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_t(input int f3, rs1, rs2, imm);
    logic [12:0] v;
    v = 13'(imm);
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3),
            v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] j_t(input int rd, imm);
    logic [20:0] v;
    v = 21'(imm);
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction

  // Reference: executes one instruction from the model's own ROM copy.
  task automatic model_step();
    logic [31:0] ins, a, b, bb, ii, is_, ib, iu, ij, npc, res;
    logic wr, take;
    int op, f3, f7, rd, sh, idx;
    exp_t e;
    ins = m_rom[(m_pc >> 2) % RD];
    op = int'(ins[6:0]);
    rd = int'(ins[11:7]);
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    a = m_regs[ins[19:15]];
    b = m_regs[ins[24:20]];
    ii = {{20{ins[31]}}, ins[31:20]};
    is_ = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'h000};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    npc = m_pc + 4;
    wr = 0;
    res = 0;
    idx = 0;
    e = '0;
    case (op)
      'h37: begin res = iu; wr = 1; end
      'h17: begin res = m_pc + iu; wr = 1; end
      'h6f: begin res = m_pc + 4; wr = 1; npc = m_pc + ij; end
      'h67: if (f3 == 0) begin
        npc = (a + ii) & 32'hFFFF_FFFE;
        res = m_pc + 4;
        wr = 1;
      end
      'h63: begin
        case (f3)
          0: take = a == b;
          1: take = a != b;
          4: take = $signed(a) < $signed(b);
          5: take = $signed(a) >= $signed(b);
          6: take = a < b;
          7: take = a >= b;
          default: take = 0;
        endcase
        if (take) npc = m_pc + ib;
      end
      'h03: if (f3 == 2) begin
        idx = int'((a + ii) >> 2) % MD;
        res = m_mem[idx];
        wr = 1;
        e.mchk = 1;
      end
      'h23: if (f3 == 2) begin
        idx = int'((a + is_) >> 2) % MD;
        m_mem[idx] = b;
        e.mchk = 1;
      end
      'h13, 'h33: begin
        bb = (op == 'h13) ? ii : b;
        sh = int'(bb % 32);
        if (op == 'h33)
          wr = f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5));
        else
          wr = (f3 != 1 && f3 != 5) || f7 == 0 || (f3 == 5 && f7 == 32);
        case (f3)
          0: res = (op == 'h33 && f7 == 32) ? a - bb : a + bb;
          1: res = a << sh;
          2: res = ($signed(a) < $signed(bb)) ? 1 : 0;
          3: res = (a < bb) ? 1 : 0;
          4: res = a ^ bb;
          5: res = (f7 == 32) ? 32'($signed(a) >>> sh) : a >> sh;
          6: res = a | bb;
          default: res = a & bb;
        endcase
      end
      default: ;
    endcase
    if (wr && rd != 0) m_regs[rd] = res;
    m_pc = npc;
    e.pc = m_pc;
    for (int i = 0; i < 32; i++) e.regs[i] = m_regs[i];
    e.midx = 10'(idx);
    e.mval = m_mem[idx];
    q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int bad;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc", dut.pc, e.pc);
      bad = -1;
      for (int i = 0; i < 32; i++)
        if (bad < 0 && dut.u_regfile.regs[i] !== e.regs[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        failures++;
        $display("FAIL regs x%0d got=%h want=%h at pc=%h", bad,
                 dut.u_regfile.regs[bad], e.regs[bad], e.pc);
      end
      if (e.mchk) chk("mem", dut.u_ram.mem[e.midx], e.mval);
    end
  end

  task automatic chk_reset_state();
    int bad;
    chk("reset_pc", dut.pc, 32'd0);
    bad = -1;
    for (int i = 0; i < 32; i++)
      if (bad < 0 && dut.u_regfile.regs[i] !== 32'd0) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL reset_regs x%0d got=%h want=0", bad,
               dut.u_regfile.regs[bad]);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      model_step();
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(q.size()), 32'd0);
  endtask

  task automatic load_rom();
    for (int i = 0; i < RD; i++) dut.u_rom._rom[i] = m_rom[i];
  endtask

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    q.delete();
  endtask

  function automatic logic [31:0] gen_instr();
    int k, f3, imm, rd, r1, r2;
    logic [31:0] w;
    k = $urandom_range(0, 9);
    rd = $urandom_range(0, 15);
    r1 = $urandom_range(0, 15);
    r2 = $urandom_range(0, 15);
    f3 = $urandom_range(0, 7);
    imm = $urandom_range(0, 4095);
    w = $urandom;
    case (k)
      0, 1: return r_t(((f3 == 0 || f3 == 5) && w[0]) ? 32 : 0,
                       f3, rd, r1, r2);
      2, 3: begin
        if (f3 == 1) imm = imm & 31;
        if (f3 == 5) imm = (imm & 31) | (w[0] ? 'h400 : 0);
        return i_t('h13, f3, rd, r1, imm);
      end
      4: return {w[31:12], 5'(rd), w[0] ? 7'h37 : 7'h17};
      5: return i_t('h03, 2, rd, 0, $urandom_range(0, 63));
      6: return s_t(0, r2, $urandom_range(0, 63));
      7: begin
        f3 = (f3 == 2 || f3 == 3) ? f3 + 4 : f3;
        imm = (w[1:0] == 0) ? -4 * $urandom_range(1, 4)
                            : 4 * $urandom_range(1, 8);
        return b_t(f3, r1, r2, imm);
      end
      8: return w[0] ? j_t(rd, 4 * $urandom_range(1, 8))
                     : i_t('h67, 0, rd, r1, imm);
      default: begin
        case (w[2:0])
          0: return 32'h0000_0000;
          1: return 32'h0000_000F;
          2: return 32'h0000_0073;
          3: return 32'h0010_0073;
          4: return r_t(1, f3, rd, r1, r2);
          default: return {w[31:7], 7'h7F};
        endcase
      end
    endcase
  endfunction

  initial begin
    for (int i = 0; i < MD; i++) m_mem[i] = 0;
    for (int i = 0; i < RD; i++) m_rom[i] = 0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 chk_reset_state();

    m_rom[0]  = i_t('h13, 0, 1, 0, 5);
    m_rom[1]  = i_t('h13, 0, 2, 0, 6);
    m_rom[2]  = i_t('h13, 0, 3, 0, -5);
    m_rom[3]  = r_t(0, 2, 4, 3, 2);
    m_rom[4]  = r_t(0, 3, 5, 3, 2);
    m_rom[5]  = r_t(32, 0, 6, 1, 2);
    m_rom[6]  = i_t('h13, 5, 7, 3, 'h401);
    m_rom[7]  = i_t('h13, 5, 8, 3, 28);
    m_rom[8]  = i_t('h13, 0, 0, 0, 7);
    m_rom[9]  = s_t(0, 2, 4);
    m_rom[10] = i_t('h03, 2, 9, 0, 4);
    m_rom[11] = i_t('h13, 0, 1, 0, 10);
    m_rom[12] = i_t('h13, 0, 1, 1, -1);
    m_rom[13] = b_t(1, 1, 0, -4);
    m_rom[14] = j_t(1, 8);
    m_rom[15] = i_t('h13, 0, 13, 0, 1);
    m_rom[16] = i_t('h13, 0, 14, 0, 81);
    m_rom[17] = i_t('h67, 0, 15, 14, 0);
    m_rom[18] = i_t('h13, 0, 13, 0, 2);
    m_rom[19] = i_t('h13, 0, 13, 0, 3);
    m_rom[20] = 32'h0000_0000;
    m_rom[21] = 32'h0000_000F;
    m_rom[22] = 32'h0000_0073;
    m_rom[23] = 32'h0010_0073;
    m_rom[24] = 32'hFFFF_FFFF;
    load_rom();
    @(negedge clk);
    #1 rst_n = 1'b1;

    // 11 straight-line ops, then ADDI + 10 two-instruction iterations.
    run(32);
    chk("loop_exit_pc", dut.pc, 32'd56);
    chk("loop_x1", dut.u_regfile.regs[1], 32'd0);
    chk("slt_x4", dut.u_regfile.regs[4], 32'd1);
    chk("sltu_x5", dut.u_regfile.regs[5], 32'd0);
    chk("sub_x6", dut.u_regfile.regs[6], 32'hFFFF_FFFF);
    chk("srai_x7", dut.u_regfile.regs[7], 32'hFFFF_FFFD);
    chk("srli_x8", dut.u_regfile.regs[8], 32'h0000_000F);
    chk("x0_zero", dut.u_regfile.regs[0], 32'd0);
    chk("lw_x9", dut.u_regfile.regs[9], 32'd6);
    chk("sw_mem1", dut.u_ram.mem[1], 32'd6);

    run(10);
    chk("jal_x1", dut.u_regfile.regs[1], 32'd60);
    chk("jal_skip_x13", dut.u_regfile.regs[13], 32'd0);
    chk("jalr_x15", dut.u_regfile.regs[15], 32'd72);
    chk("jalr_x14", dut.u_regfile.regs[14], 32'd81);
    chk("nop_pc", dut.pc, 32'd108);

    for (int r = 0; r < 3; r++) begin
      rst_n = 1'b0;
      model_reset();
      #2 chk_reset_state();
      chk("reset_keeps_ram", dut.u_ram.mem[1], m_mem[1]);
      for (int i = 0; i < RD; i++) m_rom[i] = 0;
      for (int i = 0; i < 16; i++) m_rom[i] = s_t(0, 0, 4 * i);
      for (int i = 16; i < 216; i++) m_rom[i] = gen_instr();
      load_rom();
      #8 rst_n = 1'b1;
      run(400);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
